// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and saturation limits for the signed add/sub pipeline
package addsub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef struct packed {
    logic [63:0] max;
    logic [63:0] min;
  } sat_lim_t;
  function automatic sat_lim_t sat_limits(input int unsigned width);
    sat_lim_t l;
    l.max = (64'd1 << (width - 1)) - 64'd1;
    l.min = ~l.max;
    return l;
  endfunction
endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational signed add/sub with true-overflow detect and optional saturation
module addsub_core import addsub_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             sat,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  localparam sat_lim_t LIM = sat_limits(WIDTH);
  logic [WIDTH:0] exact;
  // One extra bit holds the exact sum, so its top bit is the true sign
  always_comb begin
    exact = op == OP_SUB ? {a[WIDTH-1], a} - {b[WIDTH-1], b} : {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf = exact[WIDTH] ^ exact[WIDTH-1];
    result = ovf && sat ? (exact[WIDTH] ? LIM.min[WIDTH-1:0] : LIM.max[WIDTH-1:0]) : exact[WIDTH-1:0];
  end
endmodule

// File: rtl/addsub_signed_pipe.sv
// addsub_signed_pipe: two-stage valid/ready signed add/sub with sticky overflow status
module addsub_signed_pipe import addsub_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  input  logic             clr_status,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);
  logic [WIDTH-1:0] a_q, b_q, result_q, core_result;
  logic             op_q, sat_q, s1_valid_q, s2_valid_q, ovf_q, core_ovf;
  logic             adv1, adv2, ovf_xfer, sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign adv2 = !s2_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid_q;
  assign out_result = result_q;
  assign out_ovf = ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count = count_q;
  assign ovf_xfer = s2_valid_q && out_ready && ovf_q;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a(a_q), .b(b_q), .op(op_q), .sat(sat_q), .result(core_result), .ovf(core_ovf)
  );

  // Both stages shift together whenever the downstream slot frees up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {a_q, b_q, op_q, sat_q, s1_valid_q} <= '0;
      {result_q, ovf_q, s2_valid_q} <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) {a_q, b_q, op_q, sat_q} <= {in_a, in_b, in_op, in_sat};
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) {result_q, ovf_q} <= {core_result, core_ovf};
      end
    end
  end

  // An overflowed delivery beats a same-cycle clear, so it restarts the count at one
  always_comb begin
    sticky_d = ovf_xfer | (sticky_q & ~clr_status);
    count_d = ovf_xfer ? (clr_status ? CNT_W'(1) : (&count_q ? count_q : count_q + 1'b1)) : (clr_status ? '0 : count_q);
  end

  // Status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      count_q <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_addsub_signed_pipe.sv
// tb_addsub_signed_pipe: directed and random checks against an integer reference model
module tb_addsub_signed_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_op = 1'b0, in_sat = 1'b0, out_ready = 1'b0, clr_status = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_ovf, ovf_sticky;
  logic [7:0] out_result, ovf_count;
  logic in_ready2, out_valid2, out_ovf2, ovf_sticky2;
  logic [7:0] out_result2;
  logic [1:0] ovf_count2;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0, accepted = 0, delivered = 0;
  logic m_sticky = 1'b0;
  int m_count = 0, m_count2 = 0;
  logic [7:0] corners [9] = '{8'h00, 8'h01, 8'hff, 8'h7f, 8'h80, 8'h7e, 8'h81, 8'h40, 8'hc0};

  addsub_signed_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_sat(in_sat), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .clr_status(clr_status),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  addsub_signed_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_sat(in_sat), .out_valid(out_valid2), .out_ready(out_ready),
    .out_result(out_result2), .out_ovf(out_ovf2), .clr_status(clr_status),
    .ovf_sticky(ovf_sticky2), .ovf_count(ovf_count2)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b, input logic op, input logic sat);
    exp_t e;
    int sa, sb, x;
    sa = $signed(a);
    sb = $signed(b);
    x = op ? sa - sb : sa + sb;
    e.ovf = x > 127 || x < -128;
    e.res = (sat && e.ovf) ? (x > 0 ? 8'h7f : 8'h80) : 8'(x);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, then advance the model over the coming edge
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic op,
                      input logic sat, input logic ordy, input logic clr, input logic lat);
    logic ov_exp, ir_exp, xo;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_sat = sat; out_ready = ordy; clr_status = clr;
    #1;
    ov_exp = q.size() > 0 && cyc >= q[0].cyc + 2;
    ir_exp = !(q.size() == 2 && !ordy);
    chk("out_valid", out_valid, ov_exp);
    chk("in_ready", in_ready, ir_exp);
    chk("sticky", ovf_sticky, m_sticky);
    chk("count", ovf_count, m_count);
    chk("count_w2", ovf_count2, m_count2);
    xo = 1'b0;
    if (ov_exp) begin
      chk("result", out_result, q[0].res);
      chk("ovf", out_ovf, q[0].ovf);
      if (lat) chk("latency", cyc - q[0].cyc, 2);
      if (ordy) begin
        xo = q[0].ovf;
        void'(q.pop_front());
        delivered++;
      end
    end
    if (xo) begin
      m_sticky = 1'b1;
      m_count = clr ? 1 : (m_count == 255 ? 255 : m_count + 1);
      m_count2 = clr ? 1 : (m_count2 == 3 ? 3 : m_count2 + 1);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_count = 0;
      m_count2 = 0;
    end
    if (v && ir_exp) begin
      e = ref_model(a, b, op, sat);
      e.cyc = cyc;
      q.push_back(e);
      accepted++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int acc0, idx;
    logic [7:0] bp_a [4], bp_b [4];
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_count", ovf_count, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    step(1'b1, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h00, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h7f, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h7f, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h80, 8'hff, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h64, 8'hce, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("directed_count", m_count, 5);

    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        for (int k = 0; k < 4; k++)
          step(1'b1, corners[i], corners[j], k[0], k[1], 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("sweep_drained", q.size(), 0);

    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
    end
    acc0 = accepted;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bp_a[idx], bp_b[idx], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idx = accepted - acc0;
    end
    chk("bp_accepted", accepted - acc0, 2);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 20 && idx < 4; i++) begin
      step(1'b1, bp_a[idx], bp_b[idx], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idx = accepted - acc0;
    end
    chk("bp_all_accepted", idx, 4);
    idle(3);
    chk("bp_drained", q.size(), 0);

    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h7f, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("three_ovf_count", ovf_count, 3);
    chk("three_ovf_sticky", ovf_sticky, 1);
    step(1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_vs_ovf_count", ovf_count, 1);
    chk("clr_vs_ovf_sticky", ovf_sticky, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h80, 8'h7f, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("cnt_w2_saturated", ovf_count2, 3);
    chk("cnt_w8_six", ovf_count, 6);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0), 1'b0);
    idle(3);
    chk("random_drained", q.size(), 0);
    chk("accept_deliver", delivered, accepted);

    step(1'b1, 8'h7f, 8'h7f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("inflight_before_rst", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", out_result, 0);
    chk("midrst_ovf", out_ovf, 0);
    chk("midrst_sticky", ovf_sticky, 0);
    chk("midrst_count", ovf_count, 0);
    q.delete();
    m_sticky = 1'b0;
    m_count = 0;
    m_count2 = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
